// File: rtl/move_input_conditioner.sv
// Switch front end: synchronizes and debounces nine cell switches, detects presses,
// and arbitrates to at most one accepted or rejected move per cycle.
module move_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] sw_in,
    input  logic [8:0] occupied,
    input  logic       dis,
    output logic [8:0] move_onehot,
    output logic       move_valid,
    output logic       move_reject,
    output logic [1:0] reject_code,
    output logic [3:0] move_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_OCCUPIED = 2'b01;
    localparam logic [1:0] CODE_MULTIPLE = 2'b10;
    localparam logic [1:0] CODE_LOCKED   = 2'b11;

    logic [8:0]    s1;
    logic [8:0]    s2;
    logic [8:0]    db;
    logic [8:0]    db_next;
    logic [8:0]    rise;
    logic [CW-1:0] cnt      [9];
    logic [CW-1:0] cnt_next [9];

    logic          accept;
    logic          reject;
    logic [1:0]    code;

    // A bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples;
    // any agreeing sample restarts the count.
    always_comb begin
        db_next = db;
        for (int i = 0; i < 9; i++) begin
            cnt_next[i] = '0;
            if (s2[i] != db[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    db_next[i] = s2[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        accept = 1'b0;
        reject = 1'b0;
        code   = CODE_NONE;
        if (rise != 9'd0) begin
            if (dis) begin
                reject = 1'b1;
                code   = CODE_LOCKED;
            end else if ((rise & (rise - 9'd1)) != 9'd0) begin
                reject = 1'b1;
                code   = CODE_MULTIPLE;
            end else if ((rise & occupied) != 9'd0) begin
                reject = 1'b1;
                code   = CODE_OCCUPIED;
            end else begin
                accept = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= '0;
            s2          <= '0;
            db          <= '0;
            rise        <= '0;
            for (int i = 0; i < 9; i++) cnt[i] <= '0;
            move_onehot <= '0;
            move_valid  <= 1'b0;
            move_reject <= 1'b0;
            reject_code <= CODE_NONE;
            move_count  <= 4'd0;
        end else begin
            s1          <= sw_in;
            s2          <= s1;
            db          <= db_next;
            for (int i = 0; i < 9; i++) cnt[i] <= cnt_next[i];
            rise        <= db_next & ~db;
            move_valid  <= accept;
            move_reject <= reject;
            reject_code <= code;
            move_onehot <= accept ? rise : 9'd0;
            if (accept && move_count != 4'd9) begin
                move_count <= move_count + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_move_input_conditioner.sv
// Directed bench for move_input_conditioner with DEBOUNCE_CYCLES = 4.
module tb_move_input_conditioner;

    logic       clk;
    logic       rst;
    logic [8:0] sw_in;
    logic [8:0] occupied;
    logic       dis;
    logic [8:0] move_onehot;
    logic       move_valid;
    logic       move_reject;
    logic [1:0] reject_code;
    logic [3:0] move_count;

    int         total;
    int         bad;
    int         exp_count;
    logic [12:0] obs;

    move_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_in       (sw_in),
        .occupied    (occupied),
        .dis         (dis),
        .move_onehot (move_onehot),
        .move_valid  (move_valid),
        .move_reject (move_reject),
        .reject_code (reject_code),
        .move_count  (move_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // obs layout: {valid, reject, code[1:0], onehot[8:0]}
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        obs = {move_valid, move_reject, reject_code, move_onehot};
    endtask

    task automatic test_reset;
        rst = 1'b1; sw_in = '0; occupied = '0; dis = 1'b0;
        tick(2);
        total++;
        if (obs !== 13'd0 || move_count !== 4'd0) begin
            bad++;
            $display("FAIL reset: got obs=%h count=%0d want obs=0 count=0", obs, move_count);
        end
        rst = 1'b0;
        exp_count = 0;
        tick(1);
    endtask

    task automatic test_single_press;
        sw_in = 9'h010;
        tick(6);
        total++;
        if (obs !== 13'd0) begin
            bad++;
            $display("FAIL single_early: got obs=%h want 0", obs);
        end
        tick(1);
        total++;
        if (obs !== {1'b1, 1'b0, 2'b00, 9'h010}) begin
            bad++;
            $display("FAIL single_pulse: got obs=%h want %h", obs, {1'b1, 1'b0, 2'b00, 9'h010});
        end
        exp_count++;
        tick(1);
        total++;
        if (move_count !== 4'(exp_count)) begin
            bad++;
            $display("FAIL single_count: got %0d want %0d", move_count, exp_count);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            total++;
            if (obs !== 13'd0) begin
                bad++;
                $display("FAIL single_held cycle %0d: got obs=%h want 0", i, obs);
            end
        end
        sw_in = '0;
        tick(10);
    endtask

    task automatic test_bounce;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                sw_in = (k < 3) ? 9'h008 : 9'h000;
                tick(1);
                total++;
                if (obs !== 13'd0) begin
                    bad++;
                    $display("FAIL bounce_quiet r=%0d k=%0d: got obs=%h want 0", r, k, obs);
                end
            end
        end
        sw_in = 9'h008;
        tick(6);
        total++;
        if (obs !== 13'd0) begin
            bad++;
            $display("FAIL bounce_early: got obs=%h want 0", obs);
        end
        tick(1);
        total++;
        if (obs !== {1'b1, 1'b0, 2'b00, 9'h008}) begin
            bad++;
            $display("FAIL bounce_pulse: got obs=%h want %h", obs, {1'b1, 1'b0, 2'b00, 9'h008});
        end
        exp_count++;
        tick(1);
        total++;
        if (obs !== 13'd0 || move_count !== 4'(exp_count)) begin
            bad++;
            $display("FAIL bounce_after: got obs=%h count=%0d want obs=0 count=%0d", obs, move_count, exp_count);
        end
        sw_in = '0;
        tick(10);
    endtask

    task automatic test_occupied_multiple;
        occupied = 9'h001;
        sw_in = 9'h001;
        tick(7);
        total++;
        if (obs !== {1'b0, 1'b1, 2'b01, 9'h000} || move_count !== 4'(exp_count)) begin
            bad++;
            $display("FAIL occupied: got obs=%h count=%0d want obs=%h count=%0d",
                     obs, move_count, {1'b0, 1'b1, 2'b01, 9'h000}, exp_count);
        end
        sw_in = '0;
        tick(10);
        occupied = '0;
        sw_in = 9'h006;
        tick(7);
        total++;
        if (obs !== {1'b0, 1'b1, 2'b10, 9'h000}) begin
            bad++;
            $display("FAIL multiple: got obs=%h want %h", obs, {1'b0, 1'b1, 2'b10, 9'h000});
        end
        tick(1);
        total++;
        if (obs !== 13'd0 || move_count !== 4'(exp_count)) begin
            bad++;
            $display("FAIL multiple_after: got obs=%h count=%0d want obs=0 count=%0d", obs, move_count, exp_count);
        end
        sw_in = '0;
        tick(10);
    endtask

    task automatic test_lock;
        dis = 1'b1;
        sw_in = 9'h020;
        tick(7);
        total++;
        if (obs !== {1'b0, 1'b1, 2'b11, 9'h000}) begin
            bad++;
            $display("FAIL lock_single: got obs=%h want %h", obs, {1'b0, 1'b1, 2'b11, 9'h000});
        end
        sw_in = '0;
        tick(10);
        sw_in = 9'h006;
        tick(7);
        total++;
        if (obs !== {1'b0, 1'b1, 2'b11, 9'h000} || move_count !== 4'(exp_count)) begin
            bad++;
            $display("FAIL lock_multiple: got obs=%h count=%0d want obs=%h count=%0d",
                     obs, move_count, {1'b0, 1'b1, 2'b11, 9'h000}, exp_count);
        end
        sw_in = '0;
        dis = 1'b0;
        tick(10);
    endtask

    task automatic test_back_to_back;
        sw_in = 9'h002;
        tick(1);
        sw_in = 9'h006;
        tick(6);
        total++;
        if (obs !== {1'b1, 1'b0, 2'b00, 9'h002}) begin
            bad++;
            $display("FAIL b2b_first: got obs=%h want %h", obs, {1'b1, 1'b0, 2'b00, 9'h002});
        end
        tick(1);
        total++;
        if (obs !== {1'b1, 1'b0, 2'b00, 9'h004}) begin
            bad++;
            $display("FAIL b2b_second: got obs=%h want %h", obs, {1'b1, 1'b0, 2'b00, 9'h004});
        end
        exp_count += 2;
        tick(1);
        total++;
        if (obs !== 13'd0 || move_count !== 4'(exp_count)) begin
            bad++;
            $display("FAIL b2b_after: got obs=%h count=%0d want obs=0 count=%0d", obs, move_count, exp_count);
        end
        sw_in = '0;
        tick(10);
    endtask

    task automatic test_saturation_reset;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_count = 0;
        for (int k = 0; k < 10; k++) begin
            sw_in = 9'b1 << (k % 9);
            tick(7);
            total++;
            if (obs !== {1'b1, 1'b0, 2'b00, sw_in}) begin
                bad++;
                $display("FAIL sat_pulse k=%0d: got obs=%h want %h", k, obs, {1'b1, 1'b0, 2'b00, sw_in});
            end
            if (exp_count < 9) exp_count++;
            tick(1);
            total++;
            if (move_count !== 4'(exp_count)) begin
                bad++;
                $display("FAIL sat_count k=%0d: got %0d want %0d", k, move_count, exp_count);
            end
            sw_in = '0;
            tick(8);
        end
        sw_in = 9'h080;
        tick(3);
        rst = 1'b1;
        tick(1);
        total++;
        if (obs !== 13'd0 || move_count !== 4'd0) begin
            bad++;
            $display("FAIL midreset: got obs=%h count=%0d want obs=0 count=0", obs, move_count);
        end
        rst = 1'b0;
        exp_count = 0;
        tick(6);
        total++;
        if (obs !== 13'd0) begin
            bad++;
            $display("FAIL midreset_early: got obs=%h want 0", obs);
        end
        tick(1);
        total++;
        if (obs !== {1'b1, 1'b0, 2'b00, 9'h080}) begin
            bad++;
            $display("FAIL midreset_pulse: got obs=%h want %h", obs, {1'b1, 1'b0, 2'b00, 9'h080});
        end
        exp_count++;
        tick(1);
        total++;
        if (move_count !== 4'(exp_count)) begin
            bad++;
            $display("FAIL midreset_count: got %0d want %0d", move_count, exp_count);
        end
        sw_in = '0;
        tick(10);
    endtask

    task automatic test_glitch;
        sw_in = 9'h100;
        tick(3);
        sw_in = '0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            total++;
            if (obs !== 13'd0 || dut.db[8] !== 1'b0) begin
                bad++;
                $display("FAIL glitch cycle %0d: got obs=%h db8=%b want obs=0 db8=0", i, obs, dut.db[8]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_count = 0;
        obs = '0;
        rst = 1'b1; sw_in = '0; occupied = '0; dis = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_press();
        test_bounce();
        test_occupied_multiple();
        test_lock();
        test_back_to_back();
        test_glitch();
        test_saturation_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
